// File: rtl/reg_file_sb_pkg.sv
// Shared types and constants for the register file and its pending-write scoreboard.
package reg_file_sb_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned REG_NUM = 32;

   typedef logic [4:0]      r_t;
   typedef logic [XLEN-1:0] data_t;

   function automatic logic is_x0(input r_t a);
      return a == '0;
   endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode read/issue port and writeback port of the register file.
interface reg_file_sb_if #(
   parameter int unsigned XLEN = reg_file_sb_pkg::XLEN
);
   reg_file_sb_pkg::r_t rs1_addr;
   reg_file_sb_pkg::r_t rs2_addr;
   logic                rs1_rden;
   logic                rs2_rden;
   reg_file_sb_pkg::r_t rd_addr;
   logic                rd_issue;
   reg_file_sb_pkg::r_t wb_addr;
   logic [XLEN-1:0]     wb_data;
   logic                wb_en;
   logic [XLEN-1:0]     rs1_data;
   logic [XLEN-1:0]     rs2_data;
   logic                stall;

   modport master (
      output rs1_addr, rs2_addr, rs1_rden, rs2_rden, rd_addr, rd_issue,
             wb_addr, wb_data, wb_en,
      input  rs1_data, rs2_data, stall
   );

   modport slave (
      input  rs1_addr, rs2_addr, rs1_rden, rs2_rden, rd_addr, rd_issue,
             wb_addr, wb_data, wb_en,
      output rs1_data, rs2_data, stall
   );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register pending-writer counters; produces source hazards and issue overflow.
// Honours REG_BYPASS_EN: a final same-cycle writeback clears the source hazard.
module reg_scoreboard
   import reg_file_sb_pkg::*;
#(
   parameter int unsigned PEND_W = 2
) (
   input  logic clk,
   input  logic rst,
   input  r_t   rs1_addr,
   input  logic rs1_rden,
   input  r_t   rs2_addr,
   input  logic rs2_rden,
   input  r_t   rd_addr,
   input  logic rd_issue,
   input  r_t   wb_addr,
   input  logic wb_en,
   input  logic stall,
   output logic hz_1,
   output logic hz_2,
   output logic ovf
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

   logic [PEND_W-1:0] pend [REG_NUM];
   logic [PEND_W-1:0] p1, p2, pd;
   logic              wb_hit1, wb_hit2, wb_hitd;

   always_comb begin
      p1      = pend[rs1_addr];
      p2      = pend[rs2_addr];
      pd      = pend[rd_addr];
      wb_hit1 = wb_en && (wb_addr == rs1_addr);
      wb_hit2 = wb_en && (wb_addr == rs2_addr);
      wb_hitd = wb_en && (wb_addr == rd_addr);
      hz_1    = rs1_rden && !is_x0(rs1_addr) && (p1 != '0);
      hz_2    = rs2_rden && !is_x0(rs2_addr) && (p2 != '0);
`ifdef REG_BYPASS_EN
      if (wb_hit1 && (p1 == PEND_ONE)) hz_1 = 1'b0;
      if (wb_hit2 && (p2 == PEND_ONE)) hz_2 = 1'b0;
`endif
      ovf     = rd_issue && !is_x0(rd_addr) && (pd == PEND_MAX) && !wb_hitd;
   end

   // x0 is left out of the update loop so its count stays at the reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < REG_NUM; i++) pend[i] <= '0;
      end else begin
         for (int unsigned i = 1; i < REG_NUM; i++) begin
            if ((!stall && rd_issue && (rd_addr == r_t'(i))) &&
                !(wb_en && (wb_addr == r_t'(i))))
               pend[i] <= pend[i] + 1'b1;
            else if ((wb_en && (wb_addr == r_t'(i))) &&
                     !(!stall && rd_issue && (rd_addr == r_t'(i))) &&
                     (pend[i] != '0))
               pend[i] <= pend[i] - 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with registered read ports and pending-write scoreboard.
// Optional REG_BYPASS_EN forwards a same-cycle writeback into the read capture.
module reg_file_sb #(
   parameter int unsigned XLEN   = reg_file_sb_pkg::XLEN,
   parameter int unsigned PEND_W = 2
) (
   input logic         clk,
   input logic         rst,
   reg_file_sb_if.slave bus
);
   import reg_file_sb_pkg::*;

   logic [XLEN-1:0] regs [REG_NUM];
   logic [XLEN-1:0] rs1_q, rs2_q;
   logic [XLEN-1:0] next1, next2;
   logic            hz_1, hz_2, ovf, stall;

   reg_scoreboard #(.PEND_W(PEND_W)) u_sb (
      .clk     (clk),
      .rst     (rst),
      .rs1_addr(bus.rs1_addr),
      .rs1_rden(bus.rs1_rden),
      .rs2_addr(bus.rs2_addr),
      .rs2_rden(bus.rs2_rden),
      .rd_addr (bus.rd_addr),
      .rd_issue(bus.rd_issue),
      .wb_addr (bus.wb_addr),
      .wb_en   (bus.wb_en),
      .stall   (stall),
      .hz_1    (hz_1),
      .hz_2    (hz_2),
      .ovf     (ovf)
   );

   assign stall = hz_1 | hz_2 | ovf;

   always_comb begin
      next1 = is_x0(bus.rs1_addr) ? '0 : regs[bus.rs1_addr];
      next2 = is_x0(bus.rs2_addr) ? '0 : regs[bus.rs2_addr];
`ifdef REG_BYPASS_EN
      if (bus.wb_en && !is_x0(bus.rs1_addr) && (bus.wb_addr == bus.rs1_addr))
         next1 = bus.wb_data;
      if (bus.wb_en && !is_x0(bus.rs2_addr) && (bus.wb_addr == bus.rs2_addr))
         next2 = bus.wb_data;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < REG_NUM; i++) regs[i] <= '0;
         rs1_q <= '0;
         rs2_q <= '0;
      end else begin
         if (bus.wb_en && !is_x0(bus.wb_addr)) regs[bus.wb_addr] <= bus.wb_data;
         if (bus.rs1_rden && !stall) rs1_q <= next1;
         if (bus.rs2_rden && !stall) rs2_q <= next2;
      end
   end

   assign bus.rs1_data = rs1_q;
   assign bus.rs2_data = rs2_q;
   assign bus.stall    = stall;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed vector table plus randomized traffic against a counting reference model.
module tb_reg_file_sb;

   localparam int unsigned PMAX = 3;
`ifdef REG_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic        rst;
      logic [4:0]  a1;
      logic        e1;
      logic [4:0]  a2;
      logic        e2;
      logic [4:0]  rd;
      logic        iss;
      logic [4:0]  wa;
      logic        we;
      logic [31:0] wd;
      logic        xs;
      logic [31:0] x1;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_file_sb_if #(.XLEN(32)) bus ();
   reg_file_sb #(.XLEN(32), .PEND_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

   int unsigned mpend [32];
   logic [31:0] mreg  [32];
   logic [31:0] m1, m2;
   int          nvec = 0;
   int          nbad = 0;
   vec_t        vt [$];

   function automatic vec_t mk(logic r, logic [4:0] a1, logic e1, logic [4:0] a2, logic e2,
                               logic [4:0] rd, logic iss, logic [4:0] wa, logic we,
                               logic [31:0] wd, logic xs, logic [31:0] x1);
      vec_t v;
      v.rst = r; v.a1 = a1; v.e1 = e1; v.a2 = a2; v.e2 = e2; v.rd = rd; v.iss = iss;
      v.wa = wa; v.we = we; v.wd = wd; v.xs = xs; v.x1 = x1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   // A source blocks while any writer is outstanding, unless bypass lets the last one through.
   function automatic logic src_blocked(logic en, logic [4:0] a, vec_t v);
      if (!en || a == 0 || mpend[a] == 0) return 1'b0;
      if (BYP && v.we && v.wa == a && mpend[a] == 1) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic model_stall(vec_t v);
      logic full;
      full = v.iss && v.rd != 0 && mpend[v.rd] == PMAX && !(v.we && v.wa == v.rd);
      return src_blocked(v.e1, v.a1, v) || src_blocked(v.e2, v.a2, v) || full;
   endfunction

   function automatic logic [31:0] model_read(logic [4:0] a, vec_t v);
      if (a == 0) return 32'h0;
      if (BYP && v.we && v.wa == a) return v.wd;
      return mreg[a];
   endfunction

   task automatic model_update(input vec_t v, input logic st);
      if (v.rst) begin
         for (int i = 0; i < 32; i++) begin mpend[i] = 0; mreg[i] = 32'h0; end
         m1 = 32'h0; m2 = 32'h0;
      end else begin
         if (v.e1 && !st) m1 = model_read(v.a1, v);
         if (v.e2 && !st) m2 = model_read(v.a2, v);
         if (!st && v.iss && v.rd != 0) mpend[v.rd]++;
         if (v.we && v.wa != 0) begin
            mreg[v.wa] = v.wd;
            if (mpend[v.wa] > 0) mpend[v.wa]--;
         end
      end
   endtask

   task automatic apply(input vec_t v, input bit tab, input int idx);
      logic st;
      @(negedge clk);
      rst = v.rst;
      bus.rs1_addr = v.a1; bus.rs1_rden = v.e1;
      bus.rs2_addr = v.a2; bus.rs2_rden = v.e2;
      bus.rd_addr  = v.rd; bus.rd_issue = v.iss;
      bus.wb_addr  = v.wa; bus.wb_en    = v.we; bus.wb_data = v.wd;
      #1;
      st = model_stall(v);
      chk($sformatf("stall_model[%0d]", idx), {31'h0, bus.stall}, {31'h0, st});
      if (tab) chk($sformatf("stall_tab[%0d]", idx), {31'h0, bus.stall}, {31'h0, v.xs});
      @(posedge clk);
      model_update(v, st);
      #1;
      chk($sformatf("rs1_model[%0d]", idx), bus.rs1_data, m1);
      chk($sformatf("rs2_model[%0d]", idx), bus.rs2_data, m2);
      if (tab) chk($sformatf("rs1_tab[%0d]", idx), bus.rs1_data, v.x1);
   endtask

   initial begin
      vec_t v;
      for (int i = 0; i < 32; i++) begin mpend[i] = 0; mreg[i] = 32'h0; end
      m1 = 32'h0; m2 = 32'h0;
      rst = 1'b1;
      bus.rs1_addr = '0; bus.rs1_rden = 1'b0; bus.rs2_addr = '0; bus.rs2_rden = 1'b0;
      bus.rd_addr = '0; bus.rd_issue = 1'b0; bus.wb_addr = '0; bus.wb_en = 1'b0;
      bus.wb_data = '0;

      //          rst a1 e1 a2 e2 rd iss wa we wd            xs  x1
      vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0));
      vt.push_back(mk(0, 5, 1, 6, 1, 0, 0, 0, 0, 32'h0,        0, 32'h0));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h0));
      vt.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 32'h0,        0, 32'h0));
      vt.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 32'h0000AA55, 0, 32'h0));
      vt.push_back(mk(0, 2, 1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0000AA55));
      vt.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 0, 32'h0,        0, 32'h0000AA55));
      vt.push_back(mk(0, 3, 1, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h0000AA55));
      if (BYP) vt.push_back(mk(0, 3, 1, 0, 0, 0, 0, 3, 1, 32'h1234, 0, 32'h1234));
      else     vt.push_back(mk(0, 3, 1, 0, 0, 0, 0, 3, 1, 32'h1234, 1, 32'h0000AA55));
      vt.push_back(mk(0, 3, 1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h1234));
      vt.push_back(mk(0, 0, 0, 0, 0, 7, 1, 0, 0, 32'h0,        0, 32'h1234));
      vt.push_back(mk(0, 0, 0, 0, 0, 7, 1, 0, 0, 32'h0,        0, 32'h1234));
      vt.push_back(mk(0, 0, 0, 0, 0, 7, 1, 0, 0, 32'h0,        0, 32'h1234));
      vt.push_back(mk(0, 0, 0, 0, 0, 7, 1, 0, 0, 32'h0,        1, 32'h1234));
      vt.push_back(mk(0, 0, 0, 0, 0, 7, 1, 7, 1, 32'h77,       0, 32'h1234));
      vt.push_back(mk(0, 7, 1, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h1234));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 1, 32'h70,       0, 32'h1234));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 1, 32'h71,       0, 32'h1234));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 1, 32'h72,       0, 32'h1234));
      vt.push_back(mk(0, 7, 1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h72));
      vt.push_back(mk(0, 0, 0, 0, 0, 9, 1, 0, 0, 32'h0,        0, 32'h72));
      vt.push_back(mk(0, 0, 0, 0, 0, 9, 1, 9, 1, 32'h99,       0, 32'h72));
      vt.push_back(mk(0, 9, 1, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h72));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 9, 1, 32'h9A,       0, 32'h72));
      vt.push_back(mk(0, 9, 1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h9A));
      vt.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0, 0, 32'h0,        0, 32'h9A));
      vt.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0, 0, 32'h0,        0, 32'h9A));
      vt.push_back(mk(0, 4, 1, 0, 0, 0, 0, 0, 0, 32'h0,        1, 32'h9A));
      vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4, 1, 32'h44,       0, 32'h0));
      vt.push_back(mk(0, 4, 1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0));
      vt.push_back(mk(0, 0, 0, 0, 0, 5, 1, 0, 0, 32'h0,        0, 32'h0));
      vt.push_back(mk(0, 0, 0, 5, 1, 0, 0, 0, 0, 32'h0,        1, 32'h0));

      foreach (vt[i]) apply(vt[i], 1'b1, i);

      for (int n = 0; n < 3000; n++) begin
         v.rst = ($urandom_range(0, 199) == 0);
         v.a1  = 5'($urandom_range(0, 7)); v.e1 = 1'($urandom_range(0, 1));
         v.a2  = 5'($urandom_range(0, 7)); v.e2 = 1'($urandom_range(0, 1));
         v.rd  = 5'($urandom_range(0, 7)); v.iss = ($urandom_range(0, 1) == 0);
         v.wa  = 5'($urandom_range(0, 7)); v.we = ($urandom_range(0, 4) < 2);
         v.wd  = $urandom;
         v.xs  = 1'b0; v.x1 = 32'h0;
         apply(v, 1'b0, 1000 + n);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
